// File: rtl/pio_in_edge_irq.sv
`default_nettype none
// ============================================================================
// Module   : pio_in_edge_irq
// Brief    : Avalon-MM input PIO for push-buttons and switches. Synchronises
//            WIDTH asynchronous pins, optionally debounces them, latches the
//            selected edge type into sticky W1C bits and drives a maskable
//            level interrupt.
//            Optional feature macro: PIO_IN_DEBOUNCE_EN (per-bit debounce
//            filter of DEBOUNCE_CYCLES stable clocks).
// Revision : 1.0 - initial release
// ============================================================================
module pio_in_edge_irq #(
  parameter int WIDTH           = 8,   // 1..32 input bits
  parameter int SYNC_STAGES     = 2,   // 2..4 synchroniser flops per bit
  parameter int EDGE_TYPE       = 0,   // 0 rising, 1 falling, 2 any
  parameter int DEBOUNCE_CYCLES = 16   // stable clocks, debounce builds only
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_ADDR_DATA = 2'd0;
  localparam logic [1:0] c_ADDR_MASK = 2'd2;
  localparam logic [1:0] c_ADDR_EDGE = 2'd3;

  // The arming window covers the time it takes a pin level present at reset
  // to reach the edge detector, so such levels never look like a new edge.
`ifdef PIO_IN_DEBOUNCE_EN
  localparam int c_ARM_MAX = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
`else
  localparam int c_ARM_MAX = SYNC_STAGES + 1;
`endif
  localparam int c_ARM_W = $clog2(c_ARM_MAX + 1);
  localparam logic [c_ARM_W-1:0] c_ARM_TOP = c_ARM_W'(c_ARM_MAX);
  localparam logic [c_ARM_W-1:0] c_ARM_ONE = c_ARM_W'(1);

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  w_sync;
  logic [WIDTH-1:0]                  w_filtered;
  logic [WIDTH-1:0]                  r_prev;
  logic [WIDTH-1:0]                  w_edge;
  logic [WIDTH-1:0]                  r_edge_capture;
  logic [WIDTH-1:0]                  r_irq_mask;
  logic [WIDTH-1:0]                  w_clr;
  logic [c_ARM_W-1:0]                r_arm_cnt;
  logic                              w_armed;
  logic                              w_wr;
  logic [31:0]                       w_rd_mux;
  logic                              w_unused_ok;

  // Upper write-data bits beyond WIDTH have no storage behind them.
  assign w_unused_ok = &{1'b0, writedata, (DEBOUNCE_CYCLES < 2)};

  assign w_wr   = chipselect & ~write_n;
  assign w_sync = r_sync[SYNC_STAGES-1];

  // Metastability chain: stage 0 samples the pins, last stage is usable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
    end
  end

  // --------------------------------------------------------------------------
  // Optional debounce filter
  // --------------------------------------------------------------------------
`ifdef PIO_IN_DEBOUNCE_EN
  localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_DB_W-1:0] c_DB_TOP = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_DB_W-1:0] c_DB_ONE = c_DB_W'(1);

  logic [WIDTH-1:0]             r_filtered;
  logic [WIDTH-1:0][c_DB_W-1:0] r_db_cnt;

  // Each bit only follows the synchronised pin after it has disagreed with
  // the filtered value for DEBOUNCE_CYCLES consecutive clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_filtered <= '0;
      r_db_cnt   <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_sync[i] != r_filtered[i]) begin
          if (r_db_cnt[i] == c_DB_TOP) begin
            r_filtered[i] <= w_sync[i];
            r_db_cnt[i]   <= '0;
          end else begin
            r_db_cnt[i]   <= r_db_cnt[i] + c_DB_ONE;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_filtered = r_filtered;
`else
  assign w_filtered = w_sync;
`endif

  // --------------------------------------------------------------------------
  // Edge detection
  // --------------------------------------------------------------------------

  // Previous filtered value for edge comparison.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= '0;
    end else begin
      r_prev <= w_filtered;
    end
  end

  generate
    if (EDGE_TYPE == 0) begin : g_edge_rise
      assign w_edge = w_filtered & ~r_prev;
    end else if (EDGE_TYPE == 1) begin : g_edge_fall
      assign w_edge = ~w_filtered & r_prev;
    end else begin : g_edge_any
      assign w_edge = w_filtered ^ r_prev;
    end
  endgenerate

  // Arming counter climbs once after reset and then parks at its top value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm_cnt <= '0;
    end else if (r_arm_cnt != c_ARM_TOP) begin
      r_arm_cnt <= r_arm_cnt + c_ARM_ONE;
    end
  end

  assign w_armed = (r_arm_cnt == c_ARM_TOP);

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  assign w_clr = (w_wr && (address == c_ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  // Sticky edge bits; a new edge in the clearing cycle keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_capture <= '0;
    end else begin
      r_edge_capture <= (w_armed ? w_edge : '0) | (r_edge_capture & ~w_clr);
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask <= '0;
    end else if (w_wr && (address == c_ADDR_MASK)) begin
      r_irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // Read mux; unimplemented bits and address 1 return zero.
  always_comb begin
    w_rd_mux = '0;
    case (address)
      c_ADDR_DATA: w_rd_mux[WIDTH-1:0] = w_filtered;
      c_ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_irq_mask;
      c_ADDR_EDGE: w_rd_mux[WIDTH-1:0] = r_edge_capture;
      default:     w_rd_mux = '0;
    endcase
  end

  // Read data is registered every clock, independent of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= w_rd_mux;
    end
  end

  assign irq = |(r_edge_capture & r_irq_mask);

endmodule
`default_nettype wire
